// File: rtl/seg7_count_monitor_if.sv
// Two-digit 7-segment display bus plus the checker's decoded status outputs.
// The display driver side is the master, the checker is the slave.
interface seg7_count_monitor_if;
  logic [6:0] digit1;
  logic [6:0] digit0;
  logic [3:0] tens;
  logic [3:0] ones;
  logic       code_ok;
  logic       step_ok;
  logic       seq_err;
  logic [7:0] err_count;
  logic       stall;
  logic       fault;

  modport master (
    output digit1, digit0,
    input  tens, ones, code_ok, step_ok, seq_err, err_count, stall, fault
  );

  modport slave (
    input  digit1, digit0,
    output tens, ones, code_ok, step_ok, seq_err, err_count, stall, fault
  );
endinterface

// File: rtl/seg7_count_monitor.sv
// Receive-side checker for a two-digit 7-segment counter display: decodes both
// digits, verifies single +1 steps with wrap, counts errors and flags stalls.
module seg7_count_monitor #(
  parameter int MAX_COUNT   = 99,
  parameter int STALL_LIMIT = 1000,
  parameter int ERR_LIMIT   = 4
) (
  input  logic                clock,
  input  logic                reset,
  seg7_count_monitor_if.slave mon
);
  localparam int              TW      = $clog2(STALL_LIMIT + 1);
  localparam logic [6:0]      MAX_V   = 7'(MAX_COUNT);
  localparam logic [TW-1:0]   STALL_V = TW'(STALL_LIMIT);
  localparam logic [7:0]      ERR_V   = 8'(ERR_LIMIT);

  // Fault is sticky, but tracking carries on underneath it, hence two fault states.
  typedef enum logic [1:0] {
    ST_SYNC        = 2'd0,
    ST_TRACK       = 2'd1,
    ST_FAULT_SYNC  = 2'd2,
    ST_FAULT_TRACK = 2'd3
  } state_t;

  function automatic logic [4:0] seg_decode(input logic [6:0] seg);
    case (seg)
      7'h3F:   seg_decode = {1'b1, 4'd0};
      7'h06:   seg_decode = {1'b1, 4'd1};
      7'h5B:   seg_decode = {1'b1, 4'd2};
      7'h4F:   seg_decode = {1'b1, 4'd3};
      7'h66:   seg_decode = {1'b1, 4'd4};
      7'h6D:   seg_decode = {1'b1, 4'd5};
      7'h7D:   seg_decode = {1'b1, 4'd6};
      7'h07:   seg_decode = {1'b1, 4'd7};
      7'h7F:   seg_decode = {1'b1, 4'd8};
      7'h6F:   seg_decode = {1'b1, 4'd9};
      default: seg_decode = 5'd0;
    endcase
  endfunction

  logic [6:0]      seg_bus [2];
  logic [1:0][3:0] dec_val;
  logic [1:0]      dec_ok;

  assign seg_bus[0] = mon.digit0;
  assign seg_bus[1] = mon.digit1;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_dec
      assign {dec_ok[gi], dec_val[gi]} = seg_decode(seg_bus[gi]);
    end
  endgenerate

  state_t        state_reg, state_next;
  logic [6:0]    prev_reg, prev_next;
  logic [TW-1:0] timer_reg, timer_next;
  logic          stall_reg, stall_next;
  logic [3:0]    tens_reg, tens_next;
  logic [3:0]    ones_reg, ones_next;
  logic          code_ok_reg, code_ok_next;
  logic          step_ok_reg, step_ok_next;
  logic          seq_err_reg, seq_err_next;
  logic [7:0]    err_count_reg, err_count_next;

  logic [6:0] value;
  logic [6:0] expected;
  logic       value_legal;
  logic       tracking;
  logic       in_fault;
  logic       track_next;
  logic       fault_next;
  logic       err_hit;

  // A legally coded value above MAX_COUNT is still treated as an illegal code.
  assign value       = 7'(dec_val[1]) * 7'd10 + 7'(dec_val[0]);
  assign value_legal = (&dec_ok) && (value <= MAX_V);
  assign expected    = (prev_reg == MAX_V) ? 7'd0 : prev_reg + 7'd1;
  assign tracking    = (state_reg == ST_TRACK) || (state_reg == ST_FAULT_TRACK);
  assign in_fault    = (state_reg == ST_FAULT_SYNC) || (state_reg == ST_FAULT_TRACK);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg     <= ST_SYNC;
      prev_reg      <= '0;
      timer_reg     <= '0;
      stall_reg     <= 1'b0;
      tens_reg      <= '0;
      ones_reg      <= '0;
      code_ok_reg   <= 1'b0;
      step_ok_reg   <= 1'b0;
      seq_err_reg   <= 1'b0;
      err_count_reg <= '0;
    end else begin
      state_reg     <= state_next;
      prev_reg      <= prev_next;
      timer_reg     <= timer_next;
      stall_reg     <= stall_next;
      tens_reg      <= tens_next;
      ones_reg      <= ones_next;
      code_ok_reg   <= code_ok_next;
      step_ok_reg   <= step_ok_next;
      seq_err_reg   <= seq_err_next;
      err_count_reg <= err_count_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    prev_next      = prev_reg;
    timer_next     = timer_reg;
    stall_next     = stall_reg;
    step_ok_next   = 1'b0;
    seq_err_next   = 1'b0;
    err_count_next = err_count_reg;
    track_next     = tracking;
    fault_next     = in_fault;
    err_hit        = 1'b0;

    // Each digit holds its last good value independently.
    tens_next    = dec_ok[1] ? dec_val[1] : tens_reg;
    ones_next    = dec_ok[0] ? dec_val[0] : ones_reg;
    code_ok_next = &dec_ok;

    if (!tracking) begin
      if (value_legal) begin
        prev_next  = value;
        track_next = 1'b1;
        timer_next = '0;
        stall_next = 1'b0;
      end
    end else if (!value_legal) begin
      seq_err_next = 1'b1;
      err_hit      = 1'b1;
      track_next   = 1'b0;
      timer_next   = '0;
      stall_next   = 1'b0;
    end else if (value == prev_reg) begin
      if (timer_reg != STALL_V) begin
        timer_next = timer_reg + 1'b1;
      end
      stall_next = (timer_next == STALL_V);
    end else if (value == expected) begin
      step_ok_next = 1'b1;
      prev_next    = value;
      timer_next   = '0;
      stall_next   = 1'b0;
    end else begin
      seq_err_next = 1'b1;
      err_hit      = 1'b1;
      prev_next    = value;
      timer_next   = '0;
      stall_next   = 1'b0;
    end

    if (err_hit && (err_count_reg != 8'hFF)) begin
      err_count_next = err_count_reg + 8'd1;
    end
    if (err_hit && (err_count_next >= ERR_V)) begin
      fault_next = 1'b1;
    end

    case ({fault_next, track_next})
      2'b00:   state_next = ST_SYNC;
      2'b01:   state_next = ST_TRACK;
      2'b10:   state_next = ST_FAULT_SYNC;
      default: state_next = ST_FAULT_TRACK;
    endcase
  end

  assign mon.tens      = tens_reg;
  assign mon.ones      = ones_reg;
  assign mon.code_ok   = code_ok_reg;
  assign mon.step_ok   = step_ok_reg;
  assign mon.seq_err   = seq_err_reg;
  assign mon.err_count = err_count_reg;
  assign mon.stall     = stall_reg;
  assign mon.fault     = in_fault;
endmodule
